// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and default sizing for the 2R1W register file.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_clear_ctrl.sv
// ============================================================================
// Module   : regfile_clear_ctrl
// Purpose  : Bulk-clear sequencer; walks every register address once.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_active,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              clr_busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state;
    rf_state_t         state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A request arriving while already clearing is dropped, not queued.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign clr_active = (state == CLEAR);
    assign clr_we     = clr_active;
    assign clr_addr   = cnt;
    assign clr_busy   = clr_active;

endmodule

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module   : regfile_2r1w
// Purpose  : 1-write / 2-read register file, registered reads, optional bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    parameter  int BYPASS = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_active;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              waddr_ok;
    logic              wr_legal;
    logic              wr_bad;
    logic              err_nxt;
    logic [1:0]        re_v;
    logic [1:0][ADDR_W-1:0] raddr_v;

    regfile_clear_ctrl #(
        .DEPTH (DEPTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .clr_active (clr_active),
        .clr_addr   (clr_addr),
        .clr_we     (clr_we),
        .clr_busy   (clr_busy)
    );

    assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
    assign wr_legal = we && !clr_active && waddr_ok;
    assign wr_bad   = we && (clr_active || !waddr_ok);
    assign re_v     = {re1, re0};
    assign raddr_v  = {raddr1, raddr0};

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem[i] <= '0;
                end else if (clr_we && (clr_addr == ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr_legal && (waddr == ADDR_W'(i))) begin
                    mem[i] <= wdata;
                end
            end
        end
    endgenerate

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_rd
            logic              addr_ok;
            logic              bad;
            logic [DATA_W-1:0] nxt;
            logic [DATA_W-1:0] q;
            logic              v;

            assign addr_ok = ({1'b0, raddr_v[p]} < DEPTH_L);
            assign bad     = re_v[p] && !addr_ok;

            // Range is checked before indexing so a non-power-of-two array is never overrun.
            always_comb begin
                nxt = '0;
                if (!clr_active && addr_ok) begin
                    if ((BYPASS != 0) && wr_legal && (waddr == raddr_v[p])) begin
                        nxt = wdata;
                    end else begin
                        nxt = mem[raddr_v[p]];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                    v <= 1'b0;
                end else begin
                    v <= re_v[p];
                    if (re_v[p]) begin
                        q <= nxt;
                    end
                end
            end
        end
    endgenerate

    assign err_nxt = wr_bad || g_rd[0].bad || g_rd[1].bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end

    assign rdata0  = g_rd[0].q;
    assign rdata1  = g_rd[1].q;
    assign rvalid0 = g_rd[0].v;
    assign rvalid1 = g_rd[1].v;

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// ============================================================================
// Module   : tb_regfile_2r1w
// Purpose  : Directed bench; default, no-bypass and DEPTH=3 instances share stimulus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_2r1w;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       re0, re1;
    logic [1:0] raddr0, raddr1;
    logic       clr_req;

    logic [7:0] a_rd0, a_rd1, b_rd0, b_rd1, c_rd0, c_rd1;
    logic       a_v0, a_v1, b_v0, b_v1, c_v0, c_v1;
    logic       a_busy, b_busy, c_busy;
    logic       a_err, b_err, c_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(8), .DEPTH(4), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .re1(re1), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(a_rd0), .rdata1(a_rd1), .rvalid0(a_v0), .rvalid1(a_v1),
        .clr_req(clr_req), .clr_busy(a_busy), .err(a_err)
    );

    regfile_2r1w #(.DATA_W(8), .DEPTH(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .re1(re1), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(b_rd0), .rdata1(b_rd1), .rvalid0(b_v0), .rvalid1(b_v1),
        .clr_req(clr_req), .clr_busy(b_busy), .err(b_err)
    );

    regfile_2r1w #(.DATA_W(8), .DEPTH(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .re1(re1), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(c_rd0), .rdata1(c_rd1), .rvalid0(c_v0), .rvalid1(c_v1),
        .clr_req(clr_req), .clr_busy(c_busy), .err(c_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0;
        re0 = 1'b0; re1 = 1'b0; raddr0 = '0; raddr1 = '0;
        clr_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("reset_rdata0", 32'(a_rd0), 32'h00);
        check("reset_rvalid0", 32'(a_v0), 32'h0);
        check("reset_busy", 32'(a_busy), 32'h0);
        check("reset_err", 32'(a_err), 32'h0);
        rst_n = 1'b1;

        // Read every address after reset on both ports.
        for (int a = 0; a < 4; a++) begin
            re0 = 1'b1; re1 = 1'b1; raddr0 = 2'(a); raddr1 = 2'(a);
            tick();
            check("rst_read_rd0", 32'(a_rd0), 32'h00);
            check("rst_read_rd1", 32'(a_rd1), 32'h00);
            check("rst_read_v0", 32'(a_v0), 32'h1);
            check("rst_read_v1", 32'(a_v1), 32'h1);
        end
        re0 = 1'b0; re1 = 1'b0;
        tick();
        check("rvalid_pulse_end", 32'({a_v0, a_v1}), 32'h0);

        // Fill 01..04, then dual read.
        for (int a = 0; a < 4; a++) begin
            we = 1'b1; waddr = 2'(a); wdata = 8'(a + 1);
            tick();
        end
        we = 1'b0;
        re0 = 1'b1; raddr0 = 2'd2; re1 = 1'b1; raddr1 = 2'd3;
        tick();
        check("dual_rd0", 32'(a_rd0), 32'h03);
        check("dual_rd1", 32'(a_rd1), 32'h04);
        check("dual_valid", 32'({a_v0, a_v1}), 32'h3);
        check("d3_rd0", 32'(c_rd0), 32'h03);
        check("d3_oor_rd1", 32'(c_rd1), 32'h00);
        check("d3_oor_v1", 32'(c_v1), 32'h1);
        check("d3_oor_err", 32'(c_err), 32'h1);
        check("d4_no_err", 32'(a_err), 32'h0);

        // Write-to-read bypass vs. pre-write value.
        re1 = 1'b0;
        we = 1'b1; waddr = 2'd1; wdata = 8'hAA; re0 = 1'b1; raddr0 = 2'd1;
        tick();
        check("bypass_on", 32'(a_rd0), 32'hAA);
        check("bypass_off", 32'(b_rd0), 32'h02);
        we = 1'b0;
        tick();
        check("bypass_off_next", 32'(b_rd0), 32'hAA);

        // Out-of-range write on DEPTH=3; legal on DEPTH=4.
        re0 = 1'b0;
        we = 1'b1; waddr = 2'd3; wdata = 8'h55;
        tick();
        check("oor_wr_err", 32'(c_err), 32'h1);
        check("inrange_wr_noerr", 32'(a_err), 32'h0);
        we = 1'b0; re0 = 1'b1; raddr0 = 2'd0;
        tick();
        check("d3_err_clears", 32'(c_err), 32'h0);
        check("d3_addr0", 32'(c_rd0), 32'h01);
        raddr0 = 2'd1;
        tick();
        check("d3_addr1", 32'(c_rd0), 32'hAA);
        raddr0 = 2'd2;
        tick();
        check("d3_addr2", 32'(c_rd0), 32'h03);
        raddr0 = 2'd3;
        tick();
        check("d3_addr3_zero", 32'(c_rd0), 32'h00);
        check("d3_addr3_valid", 32'(c_v0), 32'h1);
        check("d4_addr3", 32'(a_rd0), 32'h55);

        // Bulk clear: DEPTH=4 busy 4 cycles, DEPTH=3 busy 3 cycles.
        re0 = 1'b0; clr_req = 1'b1;
        tick();
        check("clr_busy_rise", 32'(a_busy), 32'h1);
        check("clr_err_quiet", 32'(a_err), 32'h0);
        clr_req = 1'b0; we = 1'b1; waddr = 2'd0; wdata = 8'h77;
        tick();
        check("clr_busy_c2", 32'(a_busy), 32'h1);
        check("clr_wr_err", 32'(a_err), 32'h1);
        we = 1'b0; re1 = 1'b1; raddr1 = 2'd3;
        tick();
        check("clr_read_zero", 32'(a_rd1), 32'h00);
        check("clr_read_valid", 32'(a_v1), 32'h1);
        check("clr_err_pulse_end", 32'(a_err), 32'h0);
        re1 = 1'b0;
        tick();
        check("clr_busy_c4", 32'(a_busy), 32'h1);
        check("d3_busy_done", 32'(c_busy), 32'h0);
        tick();
        check("clr_busy_fall", 32'(a_busy), 32'h0);
        re0 = 1'b1; raddr0 = 2'd0; re1 = 1'b1; raddr1 = 2'd3;
        tick();
        check("post_clr_addr0", 32'(a_rd0), 32'h00);
        check("post_clr_addr3", 32'(a_rd1), 32'h00);

        // Asynchronous reset in the middle of a clear.
        re0 = 1'b0; re1 = 1'b0;
        we = 1'b1; waddr = 2'd2; wdata = 8'h5A;
        tick();
        we = 1'b0; re0 = 1'b1; raddr0 = 2'd2;
        tick();
        check("pre_rst_rd0", 32'(a_rd0), 32'h5A);
        re0 = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        check("mid_clr_busy", 32'(a_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd0", 32'(a_rd0), 32'h00);
        check("async_rst_busy", 32'(a_busy), 32'h0);
        check("async_rst_err", 32'(a_err), 32'h0);
        #2;
        rst_n = 1'b1;
        we = 1'b1; waddr = 2'd1; wdata = 8'h3C;
        tick();
        we = 1'b0; re0 = 1'b1; raddr0 = 2'd1; re1 = 1'b1; raddr1 = 2'd2;
        tick();
        check("post_rst_write", 32'(a_rd0), 32'h3C);
        check("post_rst_cleared", 32'(a_rd1), 32'h00);
        check("post_rst_busy", 32'(a_busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
